stream_demux_n: RTL and testbench
=================================

// Module: stream_demux_n
// PURPOSE
//   Parametrised, registered 1-to-CH stream demultiplexer; next generation of the 1x16 demux.
//   Routes WIDTH-bit beats from one valid/ready source to one of CH channels.
//   Each channel has a one-entry output buffer with independent backpressure.
//   Optional round-robin scan mode and drop reporting for out-of-range selects.
//   Sits between a single producer (UART RX, switch bank) and per-channel consumers on the Basys3 fabric.
// PARAMETERS
//   WIDTH  8   data width of each beat, >= 1
//   CH     16  number of output channels, 2..64
//   SELW   4   select width; must satisfy 2**SELW >= CH
// PORTS
//   clk       in   1         system clock; all state updates on rising edge
//   rst       in   1         synchronous, active-high reset
//   in_valid  in   1         source beat valid
//   in_ready  out  1         block can accept a beat this cycle (combinational)
//   in_data   in   WIDTH     source beat data
//   sel       in   SELW      target channel; used only when scan_en = 0
//   scan_en   in   1         1 = round-robin target from internal pointer; sel ignored
//   y_valid   out  CH        per-channel buffer full
//   y_ready   in   CH        per-channel consumer ready
//   y_data    out  CH*WIDTH  channel k occupies y_data[k*WIDTH +: WIDTH]
//   rr_ptr    out  SELW      current round-robin pointer
//   drop_err  out  1         one-cycle pulse: previous accepted beat was dropped
//   beat_cnt  out  16        count of beats delivered into channel buffers
// BEHAVIOUR
//   Reset (rst = 1 at a clock edge): y_valid = 0, y_data = 0, rr_ptr = 0, drop_err = 0, beat_cnt = 0.
//   In-flight buffered data is discarded; in_ready = 0 while rst = 1.
//   Target selection: t = scan_en ? rr_ptr : sel. t is invalid when t >= CH (only possible with sel).
//   free[k] = !y_valid[k] || y_ready[k]; a channel can be drained and refilled in the same cycle.
//   in_ready = !rst && (t invalid || free[t]).
//   Accept = in_valid && in_ready. in_data/sel are sampled only on accept.
//   Accept with valid t:
//     - y_data[t] <= in_data and y_valid[t] <= 1. Latency is one clock: visible the cycle after accept.
//     - beat_cnt <= beat_cnt + 1, wrapping 16'hFFFF -> 0.
//   Accept with invalid t:
//     - beat consumed and discarded; drop_err = 1 in the next cycle only.
//     - no channel state or beat_cnt changes.
//   Drain: y_valid[k] && y_ready[k] && !(accept to k) -> y_valid[k] <= 0; y_data[k] holds its last value.
//   Drain and accept to k in the same cycle: y_valid[k] stays 1 and y_data[k] takes the new beat.
//   Channels are independent; a stalled channel never blocks beats bound for others.
//   Round-robin pointer:
//     - On accept with scan_en = 1: rr_ptr <= (rr_ptr == CH-1) ? 0 : rr_ptr + 1.
//     - No other event moves rr_ptr, so it holds while scan_en = 0.
//     - scan_en may toggle on any cycle; the new mode takes effect the same cycle.
//   in_valid with no accept: the source must hold in_data/sel stable. The block holds no state for it.
//   At most one beat is accepted per clock; no combinational path from in_valid to in_ready.
// TESTING
//   Reset, then sel = 5, data 8'hA5, one beat, y_ready = 0
//     -> next cycle y_valid = 16'h0020, y_data[5] = A5, beat_cnt = 1.
//   Channel 5 full, y_ready[5] = 0, sel = 5 -> in_ready = 0 and no state change.
//   Same setup, then raise y_ready[5] with a new beat 8'h3C
//     -> accepted the same cycle; y_valid[5] stays 1; y_data[5] = 3C next cycle.
//   scan_en = 1, all y_ready = 1, 18 beats 0..17
//     -> channels 0..15 receive 0..15; channel 0 then receives 16, channel 1 receives 17; rr_ptr = 2.
//   CH = 10, sel = 12, one beat -> in_ready = 1, drop_err pulses one cycle, no y_valid bit set, beat_cnt unchanged.
//   Several channels full, then assert rst for one cycle -> all outputs zero next cycle; a fresh beat routes normally.

Source files
------------

// File: rtl/stream_demux_n.sv
// Registered 1-to-CH stream demultiplexer. Each channel has a one-entry buffer and its own backpressure.
// Optional round-robin targeting and a drop pulse for beats sent to a select with no channel.
module stream_demux_n #(
  parameter int WIDTH = 8,
  parameter int CH    = 16,
  parameter int SELW  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SELW-1:0]       sel,
  input  logic                  scan_en,
  output logic [CH-1:0]         y_valid,
  input  logic [CH-1:0]         y_ready,
  output logic [CH*WIDTH-1:0]   y_data,
  output logic [SELW-1:0]       rr_ptr,
  output logic                  drop_err,
  output logic [15:0]           beat_cnt
);

  // Handshake: a beat moves on any edge where valid && ready. in_ready depends only on
  // rst, the target and channel state, never on in_valid. A producer that is not accepted
  // holds in_data/sel; a channel buffer holds y_data[k] while y_valid[k] && !y_ready[k].

  logic [SELW-1:0]  tgt;
  logic             tgt_ok;
  logic             tgt_free;
  logic [CH-1:0]    free;
  logic [CH-1:0]    hit;
  logic             accept;
  logic [WIDTH-1:0] buf_q [CH];

  always_comb begin
    tgt      = scan_en ? rr_ptr : sel;
    tgt_ok   = (32'(tgt) < 32'($unsigned(CH)));
    tgt_free = 1'b0;
    free     = '0;
    hit      = '0;
    for (int k = 0; k < CH; k++) begin
      // A full buffer whose consumer is ready this cycle can be refilled on the same edge.
      free[k] = !y_valid[k] || y_ready[k];
      if (32'(tgt) == 32'($unsigned(k))) begin
        tgt_free = free[k];
        hit[k]   = 1'b1;
      end
    end
  end

  // Out-of-range targets are always ready so the beat is swallowed instead of stalling the source.
  assign in_ready = !rst && (!tgt_ok || tgt_free);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      y_valid  <= '0;
      rr_ptr   <= '0;
      drop_err <= 1'b0;
      beat_cnt <= '0;
      for (int k = 0; k < CH; k++) begin
        buf_q[k] <= '0;
      end
    end else begin
      drop_err <= accept && !tgt_ok;
      if (accept && tgt_ok) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
      if (accept && scan_en) begin
        rr_ptr <= (rr_ptr == SELW'(CH - 1)) ? '0 : rr_ptr + 1'b1;
      end
      for (int k = 0; k < CH; k++) begin
        if (accept && hit[k]) begin
          y_valid[k] <= 1'b1;
          buf_q[k]   <= in_data;
        end else if (y_ready[k]) begin
          y_valid[k] <= 1'b0;
        end
      end
    end
  end

  for (genvar g = 0; g < CH; g++) begin : g_out
    assign y_data[g*WIDTH +: WIDTH] = buf_q[g];
  end

endmodule

// File: tb/tb_stream_demux_n.sv
// Directed bench for stream_demux_n: a 16-channel instance and a 10-channel instance
// (the latter exercises out-of-range selects and pointer wrap at CH-1).
module tb_stream_demux_n;

  logic clk;
  logic rst;

  logic         in_valid, in_ready, scan_en, drop_err;
  logic [7:0]   in_data;
  logic [3:0]   sel, rr_ptr;
  logic [15:0]  y_valid, y_ready, beat_cnt;
  logic [127:0] y_data;

  logic         in_valid10, in_ready10, scan_en10, drop_err10;
  logic [7:0]   in_data10;
  logic [3:0]   sel10, rr_ptr10;
  logic [9:0]   y_valid10, y_ready10;
  logic [15:0]  beat_cnt10;
  logic [79:0]  y_data10;

  int checks = 0;
  int errors = 0;

  stream_demux_n #(.WIDTH(8), .CH(16), .SELW(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .sel(sel), .scan_en(scan_en), .y_valid(y_valid), .y_ready(y_ready), .y_data(y_data),
    .rr_ptr(rr_ptr), .drop_err(drop_err), .beat_cnt(beat_cnt)
  );

  stream_demux_n #(.WIDTH(8), .CH(10), .SELW(4)) u_dut10 (
    .clk(clk), .rst(rst), .in_valid(in_valid10), .in_ready(in_ready10), .in_data(in_data10),
    .sel(sel10), .scan_en(scan_en10), .y_valid(y_valid10), .y_ready(y_ready10), .y_data(y_data10),
    .rr_ptr(rr_ptr10), .drop_err(drop_err10), .beat_cnt(beat_cnt10)
  );

  // Clock and reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one edge, then settle 1 ns past it before touching inputs or sampling.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] ch16(input int k);
    return y_data[k*8 +: 8];
  endfunction

  function automatic logic [7:0] ch10(input int k);
    return y_data10[k*8 +: 8];
  endfunction

  initial begin
    rst = 1'b1;
    in_valid = 0; in_data = 0; sel = 0; scan_en = 0; y_ready = 0;
    in_valid10 = 0; in_data10 = 0; sel10 = 0; scan_en10 = 0; y_ready10 = 0;
    tick();
    tick();
    in_valid = 1'b1;
    #1;
    check("ready_low_in_reset", in_ready, 0);
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("rst_y_valid", y_valid, 0);
    check("rst_y_data_zero", (y_data == '0), 1);
    check("rst_rr_ptr", rr_ptr, 0);
    check("rst_drop_err", drop_err, 0);
    check("rst_beat_cnt", beat_cnt, 0);

    // One beat to channel 5 with no consumer ready
    sel = 4'd5; in_data = 8'hA5; in_valid = 1'b1;
    #1;
    check("ready_ch5_empty", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("ch5_y_valid", y_valid, 16'h0020);
    check("ch5_data_a5", ch16(5), 8'hA5);
    check("ch5_beat_cnt", beat_cnt, 1);

    // Channel 5 full and stalled: beat must wait
    in_data = 8'h77; in_valid = 1'b1;
    #1;
    check("ready_ch5_stalled", in_ready, 0);
    tick();
    check("stall_data_held", ch16(5), 8'hA5);
    check("stall_beat_cnt", beat_cnt, 1);
    check("stall_y_valid", y_valid, 16'h0020);

    // Stalled channel 5 does not block channel 2
    sel = 4'd2; in_data = 8'h11;
    #1;
    check("ready_ch2_free", in_ready, 1);
    tick();
    check("ch2_y_valid", y_valid, 16'h0024);
    check("ch2_data", ch16(2), 8'h11);
    check("ch2_beat_cnt", beat_cnt, 2);

    // Drain and refill channel 5 on the same edge
    sel = 4'd5; in_data = 8'h3C; y_ready = 16'h0020;
    #1;
    check("ready_ch5_drain", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("refill_y_valid", y_valid, 16'h0024);
    check("refill_data_3c", ch16(5), 8'h3C);
    check("refill_beat_cnt", beat_cnt, 3);
    tick();
    check("drain_y_valid", y_valid, 16'h0004);
    check("drain_data_held", ch16(5), 8'h3C);

    // Round-robin scan, 18 beats, all consumers ready, sel ignored
    y_ready = 16'hFFFF; scan_en = 1'b1; sel = 4'd9;
    for (int i = 0; i < 18; i++) begin
      in_data = 8'(i); in_valid = 1'b1;
      tick();
      if (i == 0) begin
        check("scan_first_y_valid", y_valid, 16'h0001);
      end
    end
    in_valid = 1'b0;
    check("scan_y_valid", y_valid, 16'h0002);
    check("scan_ch0", ch16(0), 8'h10);
    check("scan_ch1", ch16(1), 8'h11);
    check("scan_ch7", ch16(7), 8'h07);
    check("scan_ch15", ch16(15), 8'h0F);
    check("scan_rr_ptr", rr_ptr, 2);
    check("scan_beat_cnt", beat_cnt, 21);

    // Pointer holds while scan is off, even across accepted beats
    scan_en = 1'b0;
    tick();
    check("rr_hold_idle", rr_ptr, 2);
    sel = 4'd3; in_data = 8'h33; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("rr_hold_sel_beat", rr_ptr, 2);
    check("sel_mode_ch3", ch16(3), 8'h33);
    tick();

    // Fill several channels, then reset for one cycle
    y_ready = 16'h0000;
    sel = 4'd1; in_data = 8'hE1; in_valid = 1'b1; tick();
    sel = 4'd4; in_data = 8'hE4; tick();
    sel = 4'd9; in_data = 8'hE9; tick();
    in_valid = 1'b0;
    check("full_y_valid", y_valid, 16'h0212);
    rst = 1'b1; sel = 4'd6; in_data = 8'h5A; in_valid = 1'b1;
    #1;
    check("ready_low_rst", in_ready, 0);
    tick();
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst2_y_valid", y_valid, 0);
    check("rst2_y_data_zero", (y_data == '0), 1);
    check("rst2_beat_cnt", beat_cnt, 0);
    check("rst2_rr_ptr", rr_ptr, 0);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("fresh_y_valid", y_valid, 16'h0040);
    check("fresh_data", ch16(6), 8'h5A);
    check("fresh_beat_cnt", beat_cnt, 1);

    // CH = 10: out-of-range select is consumed and reported
    sel10 = 4'd12; in_data10 = 8'hCC; in_valid10 = 1'b1;
    #1;
    check("ch10_ready_oob", in_ready10, 1);
    tick();
    in_valid10 = 1'b0;
    check("ch10_drop_pulse", drop_err10, 1);
    check("ch10_drop_y_valid", y_valid10, 0);
    check("ch10_drop_beat_cnt", beat_cnt10, 0);
    tick();
    check("ch10_drop_clear", drop_err10, 0);

    // CH = 10: pointer wraps from 9 back to 0
    scan_en10 = 1'b1; y_ready10 = 10'h3FF;
    for (int i = 0; i < 10; i++) begin
      in_data10 = 8'(8'h40 + i); in_valid10 = 1'b1;
      tick();
      if (i == 8) begin
        check("ch10_rr_at_9", rr_ptr10, 9);
      end
    end
    in_valid10 = 1'b0;
    check("ch10_rr_wrap", rr_ptr10, 0);
    check("ch10_ch9_data", ch10(9), 8'h49);
    check("ch10_beat_cnt", beat_cnt10, 10);
    check("ch10_y_valid", y_valid10, 10'h200);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
